// File: rtl/hex7seg_pkg.sv
// ----------------------------------------------------------------------------
// hex7seg_pkg : shared segment constants, hex decode table and width helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hex7seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a}; identical to the legacy single-digit decoder.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Never returns less than 1 so a single-value counter still gets a real bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex7seg_lzs.sv
// ----------------------------------------------------------------------------
// hex7seg_lzs : leading-zero suppression vector from the frame snapshot
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hex7seg_lzs #(
    parameter int DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] value,
    input  logic                lzs_en,
    output logic [DIGITS-1:0]   suppress
);

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_lsd
                assign suppress[i] = 1'b0;
            end else begin : g_msd
                assign suppress[i] = lzs_en && (value[4*DIGITS-1:4*i] == '0);
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/hex7seg_scan.sv
// ----------------------------------------------------------------------------
// hex7seg_scan : multiplexed DIGITS-wide hex display driver with guard interval
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hex7seg_scan
    import hex7seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic [DIGITS-1:0]   blank_mask,
    input  logic                lzs_en,
    output logic [6:0]          segs,
    output logic                dp,
    output logic [DIGITS-1:0]   digit_en,
    output logic                frame_tick
);

    localparam int PW = clog2(SCAN_DIV);
    localparam int IW = clog2(DIGITS);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] GUARD_V   = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   snap_value;
    logic [DIGITS-1:0]     snap_dp;
    logic [DIGITS-1:0]     snap_blank;
    logic                  snap_lzs;

    logic [DIGITS-1:0]     suppress;
    logic                  last_slot;
    logic                  frame_end;
    logic                  dark;
    logic [3:0]            nib;
    logic [DIGITS-1:0]     sel;

    hex7seg_lzs #(
        .DIGITS (DIGITS)
    ) u_lzs (
        .value    (snap_value),
        .lzs_en   (snap_lzs),
        .suppress (suppress)
    );

    always_comb begin
        last_slot = (pcnt == PCNT_LAST);
        frame_end = last_slot && (idx == IDX_LAST);
        nib       = snap_value[4*idx +: 4];
        dark      = snap_blank[idx] | suppress[idx];
        sel       = DIGITS'(1) << idx;
    end

    // Snapshot resets to all-blank so the first frame after reset stays dark.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcnt       <= '0;
            idx        <= '0;
            snap_value <= '0;
            snap_dp    <= '0;
            snap_blank <= '1;
            snap_lzs   <= 1'b0;
            segs       <= SEG_DASH;
            dp         <= 1'b1;
            digit_en   <= '1;
            frame_tick <= 1'b0;
        end else begin
            if (last_slot) begin
                pcnt <= '0;
                idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end

            if (frame_end) begin
                snap_value <= value;
                snap_dp    <= dp_in;
                snap_blank <= blank_mask;
                snap_lzs   <= lzs_en;
            end

            digit_en   <= (pcnt >= GUARD_V) ? ~sel : '1;
            segs       <= dark ? SEG_BLANK : hex_to_seg(nib);
            dp         <= dark | ~snap_dp[idx];
            frame_tick <= (pcnt == '0) && (idx == '0);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hex7seg_scan.sv
// ----------------------------------------------------------------------------
// tb_hex7seg_scan : directed + randomized checks against a frame-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hex7seg_scan;

    localparam int D     = 4;
    localparam int SD    = 4;
    localparam int G     = 1;
    localparam int FRAME = D * SD;

    typedef struct packed {
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  b;
        logic        l;
    } snap_t;

    localparam snap_t RESET_SNAP = '{v: 16'h0, d: 4'h0, b: 4'hF, l: 1'b0};

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_mask;
    logic        lzs_en;
    logic [6:0]  segs;
    logic        dp;
    logic [3:0]  digit_en;
    logic        frame_tick;

    int    checks   = 0;
    int    failures = 0;
    int    k        = 0;
    snap_t cur, prev, pend;
    logic [6:0] seg_tbl [16];

    hex7seg_scan #(
        .DIGITS   (D),
        .SCAN_DIV (SD),
        .GUARD    (G)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .lzs_en     (lzs_en),
        .segs       (segs),
        .dp         (dp),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
        end
    endtask

    task automatic check_dash(input string tag);
        check({tag, "_segs"}, {1'b0, segs}, 8'h3F);
        check({tag, "_dp"}, {7'b0, dp}, 8'h01);
        check({tag, "_en"}, {4'b0, digit_en}, 8'h0F);
        check({tag, "_tick"}, {7'b0, frame_tick}, 8'h00);
    endtask

    // Pins during interval k show the scan position of cycle k-1.
    task automatic check_pins();
        int j, slot, phase;
        logic dark;
        logic [6:0] e_segs;
        logic [3:0] e_en;
        logic e_dp, e_tick;
        if (k == 0) begin
            check_dash("rel");
            return;
        end
        j     = k - 1;
        slot  = (j / SD) % D;
        phase = j % SD;
        dark  = prev.b[slot] || (prev.l && slot > 0 && (prev.v >> (4 * slot)) == 16'h0);
        e_segs = dark ? 7'h7F : seg_tbl[(prev.v >> (4 * slot)) & 16'hF];
        e_dp   = dark ? 1'b1 : ~prev.d[slot];
        e_en   = (phase < G) ? 4'hF : ~(4'b0001 << slot);
        e_tick = (j % FRAME) == 0;
        check("segs", {1'b0, segs}, {1'b0, e_segs});
        check("dp", {7'b0, dp}, {7'b0, e_dp});
        check("digit_en", {4'b0, digit_en}, {4'b0, e_en});
        check("frame_tick", {7'b0, frame_tick}, {7'b0, e_tick});
    endtask

    task automatic run_cycle();
        @(negedge clk);
        prev = cur;
        if (k > 0 && (k % FRAME) == 0) cur = pend;
        check_pins();
        if ((k % FRAME) == FRAME - 1) pend = '{v: value, d: dp_in, b: blank_mask, l: lzs_en};
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic run_until(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) run_cycle();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check_dash("reset");
        end
        reset = 1'b1;
        cur   = RESET_SNAP;
        pend  = RESET_SNAP;
        k     = 0;
        @(posedge clk);
        #1;
        k = 1;
    endtask

    initial begin
        seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        reset      = 1'b0;
        value      = 16'h12AF;
        dp_in      = 4'h0;
        blank_mask = 4'h0;
        lzs_en     = 1'b0;

        do_reset(3);
        run(3 * FRAME);

        value  = 16'h0030;
        lzs_en = 1'b1;
        run(2 * FRAME);
        value = 16'h0000;
        run(2 * FRAME);

        lzs_en = 1'b0;
        value  = 16'h1111;
        run(FRAME);
        run_until(5);
        value = 16'h2222;
        run(2 * FRAME);

        dp_in      = 4'b0100;
        blank_mask = 4'b1000;
        run(2 * FRAME);

        run_until(9);
        do_reset(1);
        run(2 * FRAME);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0:       value = 16'($urandom);
                    1:       value = 16'($urandom) & 16'h0FFF;
                    2:       value = 16'($urandom) & 16'h00FF;
                    3:       value = 16'($urandom) & 16'h000F;
                    default: value = 16'h0000;
                endcase
                dp_in      = 4'($urandom);
                blank_mask = 4'($urandom) & 4'($urandom);
                lzs_en     = 1'($urandom);
            end
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 2));
            else run_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
